// File: rtl/fetch_npc_unit.sv
// F-stage PC / next-PC unit with IF/ID register. Fetches through a variable-latency
// req/ack instruction port and applies MIPS delayed-branch redirects after the delay slot.
module fetch_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_d,
  input  logic        pc_sel,
  input  logic [1:0]  b_j_jr_sel,
  input  logic [31:0] rs_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] skid, skid_nxt;
  logic [31:0] redir_tgt, redir_tgt_nxt;
  logic        redir_pend, redir_pend_nxt;
  logic [31:0] ir_nxt, pc_d_nxt, pc4_d_nxt;
  logic        valid_nxt;

  logic        redirect_en;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        load;
  logic [31:0] load_word;

  // Only an instruction that actually leaves D this cycle may steer the fetch stream.
  assign redirect_en = pc_sel & valid_d & ~stall_d;
  assign pc_plus4    = pc + 32'd4;

  // NOTE: every signal written in a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    target = pc4_d + {{14{ir_d[15]}}, ir_d[15:0], 2'b00};
    unique case (b_j_jr_sel)
      2'd1:    target = {pc4_d[31:28], ir_d[25:0], 2'b00};
      2'd2:    target = rs_d & 32'hFFFF_FFFC;
      default: target = pc4_d + {{14{ir_d[15]}}, ir_d[15:0], 2'b00};
    endcase
  end

  // A same-cycle redirect outranks one parked while the delay slot was still in flight.
  always_comb begin
    npc = pc_plus4;
    if (redirect_en)     npc = target;
    else if (redir_pend) npc = redir_tgt;
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    skid_nxt       = skid;
    redir_tgt_nxt  = redir_tgt;
    redir_pend_nxt = redir_pend;
    ir_nxt         = ir_d;
    pc_d_nxt       = pc_d;
    pc4_d_nxt      = pc4_d;
    valid_nxt      = valid_d;
    load           = 1'b0;
    load_word      = imem_rdata;

    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ack) begin
          if (stall_d) begin
            skid_nxt  = imem_rdata;
            state_nxt = HOLD;
          end else begin
            load = 1'b1;
          end
        end else begin
          // D moved on but nothing arrived to replace it: insert a bubble.
          if (!stall_d) valid_nxt = 1'b0;
          if (redirect_en) begin
            redir_tgt_nxt  = target;
            redir_pend_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!stall_d) begin
          load      = 1'b1;
          load_word = skid;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      ir_nxt         = load_word;
      pc_d_nxt       = pc;
      pc4_d_nxt      = pc_plus4;
      valid_nxt      = 1'b1;
      pc_nxt         = npc;
      redir_pend_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      skid       <= '0;
      redir_tgt  <= '0;
      redir_pend <= 1'b0;
      ir_d       <= '0;
      pc_d       <= '0;
      pc4_d      <= '0;
      valid_d    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      skid       <= skid_nxt;
      redir_tgt  <= redir_tgt_nxt;
      redir_pend <= redir_pend_nxt;
      ir_d       <= ir_nxt;
      pc_d       <= pc_d_nxt;
      pc4_d      <= pc4_d_nxt;
      valid_d    <= valid_nxt;
    end
  end

  // Both come straight from registers, so the address is stable for the whole request.
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed bench for fetch_npc_unit: stimulus pushes expected fetch addresses and issued
// IF/ID entries into queues; a negedge monitor pops and compares on each handshake.
module tb_fetch_npc_unit;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
  } issue_t;

  logic        clk;
  logic        reset_n;
  logic        stall_d;
  logic        pc_sel;
  logic [1:0]  b_j_jr_sel;
  logic [31:0] rs_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] addr_q[$];
  issue_t      issue_q[$];

  localparam logic [31:0] I0   = 32'h2001_0001;
  localparam logic [31:0] I1   = 32'h1000_FFFE;  // beq, imm -2 words
  localparam logic [31:0] I2   = 32'h2402_0007;
  localparam logic [31:0] JR4  = 32'h0080_0008;  // jr $4
  localparam logic [31:0] DS3  = 32'h2403_0003;
  localparam logic [31:0] W4   = 32'h00A0_0008;  // jr $5
  localparam logic [31:0] DS5  = 32'h2405_0005;
  localparam logic [31:0] JW   = 32'h0800_0100;  // j idx 0x100
  localparam logic [31:0] DS6  = 32'h2406_0006;
  localparam logic [31:0] JRW  = 32'h00C0_0008;  // jr $6
  localparam logic [31:0] DS7  = 32'h2407_0007;
  localparam logic [31:0] W8   = 32'h1000_0004;  // beq, imm +4 words
  localparam logic [31:0] W9   = 32'h2409_0009;
  localparam logic [31:0] W10  = 32'h240A_000A;
  localparam logic [31:0] WA   = 32'h240B_000B;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  fetch_npc_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall_d    (stall_d),
    .pc_sel     (pc_sel),
    .b_j_jr_sel (b_j_jr_sel),
    .rs_d       (rs_d),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir_d       (ir_d),
    .pc_d       (pc_d),
    .pc4_d      (pc4_d),
    .valid_d    (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_fetch(input logic [31:0] addr);
    addr_q.push_back(addr);
  endtask

  task automatic exp_issue(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] pc4);
    issue_q.push_back('{ir: ir, pc: pc, pc4: pc4});
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the next rising edge.
  task automatic step(input logic ack, input logic [31:0] rdata, input logic stall,
                      input logic psel, input logic [1:0] bsel, input logic [31:0] rs);
    imem_ack   = ack;
    imem_rdata = rdata;
    stall_d    = stall;
    pc_sel     = psel;
    b_j_jr_sel = bsel;
    rs_d       = rs;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (imem_req && imem_ack) begin
      if (addr_q.size() == 0) begin
        check("fetch_extra", 32'(addr_q.size()), 32'd1);
      end else begin
        logic [31:0] ea;
        ea = addr_q.pop_front();
        check("fetch_addr", imem_addr, ea);
      end
    end
    if (valid_d && !stall_d) begin
      if (issue_q.size() == 0) begin
        check("issue_extra", 32'(issue_q.size()), 32'd1);
      end else begin
        issue_t ei;
        ei = issue_q.pop_front();
        check("issue_ir", ir_d, ei.ir);
        check("issue_pc", pc_d, ei.pc);
        check("issue_pc4", pc4_d, ei.pc4);
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    stall_d    = 1'b0;
    pc_sel     = 1'b0;
    b_j_jr_sel = 2'd0;
    rs_d       = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, 32'h0000_3000);
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_ir",    ir_d, 32'd0);
    check("rst_pc",    pc_d, 32'd0);
    check("rst_pc4",   pc4_d, 32'd0);
    reset_n = 1'b1;

    // Sequential fetch, then a backward beq whose delay slot is acked the same cycle.
    check("idle_req", 32'(imem_req), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, '0);
    check("first_req", 32'(imem_req), 32'd1);
    exp_fetch(32'h0000_3000);
    step(1'b1, I0, 1'b0, 1'b0, 2'd0, '0);
    exp_fetch(32'h0000_3004); exp_issue(I0, 32'h0000_3000, 32'h0000_3004);
    step(1'b1, I1, 1'b0, 1'b0, 2'd0, '0);
    exp_fetch(32'h0000_3008); exp_issue(I1, 32'h0000_3004, 32'h0000_3008);
    step(1'b1, I2, 1'b0, 1'b1, 2'd0, '0);
    // target = 0x3008 + sext(0xFFFE)<<2 = 0x3008 - 8
    exp_fetch(32'h0000_3000); exp_issue(I2, 32'h0000_3008, 32'h0000_300C);
    step(1'b1, I0, 1'b0, 1'b0, 2'd0, '0);

    // jr whose delay-slot ack is three cycles late.
    exp_fetch(32'h0000_3004); exp_issue(I0, 32'h0000_3000, 32'h0000_3004);
    step(1'b1, JR4, 1'b0, 1'b0, 2'd0, '0);
    exp_issue(JR4, 32'h0000_3004, 32'h0000_3008);
    step(1'b0, '0, 1'b0, 1'b1, 2'd2, 32'h0000_4003);
    check("bubble_valid", 32'(valid_d), 32'd0);
    check("ds_addr_held", imem_addr, 32'h0000_3008);
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, '0);
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, '0);
    check("ds_addr_late", imem_addr, 32'h0000_3008);
    exp_fetch(32'h0000_3008);
    step(1'b1, DS3, 1'b0, 1'b0, 2'd0, '0);
    check("jr_target", imem_addr, 32'h0000_4000);

    // Ack under stall parks the word in the skid register; acks in HOLD are ignored.
    exp_fetch(32'h0000_4000);
    step(1'b1, W4, 1'b1, 1'b0, 2'd0, '0);
    check("hold_req", 32'(imem_req), 32'd0);
    check("hold_ir", ir_d, DS3);
    step(1'b1, JUNK, 1'b1, 1'b0, 2'd0, '0);
    check("hold_req2", 32'(imem_req), 32'd0);
    check("hold_ir2", ir_d, DS3);
    exp_issue(DS3, 32'h0000_3008, 32'h0000_300C);
    step(1'b1, JUNK, 1'b0, 1'b0, 2'd0, '0);
    check("skid_ir", ir_d, W4);
    check("skid_valid", 32'(valid_d), 32'd1);
    check("post_hold_addr", imem_addr, 32'h0000_4004);

    // jr into 0x1000_000C, then j idx 0x100 -> 0x1000_0400.
    exp_fetch(32'h0000_4004); exp_issue(W4, 32'h0000_4000, 32'h0000_4004);
    step(1'b1, DS5, 1'b0, 1'b1, 2'd2, 32'h1000_000C);
    exp_fetch(32'h1000_000C); exp_issue(DS5, 32'h0000_4004, 32'h0000_4008);
    step(1'b1, JW, 1'b0, 1'b0, 2'd0, '0);
    exp_fetch(32'h1000_0010); exp_issue(JW, 32'h1000_000C, 32'h1000_0010);
    step(1'b1, DS6, 1'b0, 1'b1, 2'd1, '0);
    check("j_target", imem_addr, 32'h1000_0400);

    // jr with low rs bits set lands on 0xFFFF_FFFC; the next PC wraps to zero.
    exp_fetch(32'h1000_0400); exp_issue(DS6, 32'h1000_0010, 32'h1000_0014);
    step(1'b1, JRW, 1'b0, 1'b0, 2'd0, '0);
    exp_fetch(32'h1000_0404); exp_issue(JRW, 32'h1000_0400, 32'h1000_0404);
    step(1'b1, DS7, 1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF);
    exp_fetch(32'hFFFF_FFFC); exp_issue(DS7, 32'h1000_0404, 32'h1000_0408);
    step(1'b1, W8, 1'b0, 1'b0, 2'd0, '0);
    check("wrap_pc4", pc4_d, 32'h0000_0000);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Reserved selector 3 behaves as a branch: 0 + (4 << 2) = 0x10.
    exp_fetch(32'h0000_0000); exp_issue(W8, 32'hFFFF_FFFC, 32'h0000_0000);
    step(1'b1, W9, 1'b0, 1'b1, 2'd3, '0);
    exp_fetch(32'h0000_0010); exp_issue(W9, 32'h0000_0000, 32'h0000_0004);
    step(1'b1, W10, 1'b0, 1'b0, 2'd0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 2'd0, '0);

    // Reset while a fetch is outstanding; the ack arriving during reset is dropped.
    check("pre_rst_req", 32'(imem_req), 32'd1);
    reset_n    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = JUNK;
    stall_d    = 1'b0;
    #1;
    check("mid_rst_req",   32'(imem_req), 32'd0);
    check("mid_rst_valid", 32'(valid_d), 32'd0);
    check("mid_rst_ir",    ir_d, 32'd0);
    check("mid_rst_pc",    pc_d, 32'd0);
    check("mid_rst_pc4",   pc4_d, 32'd0);
    check("mid_rst_addr",  imem_addr, 32'h0000_3000);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(valid_d), 32'd0);
    reset_n  = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, '0);
    check("refetch_addr", imem_addr, 32'h0000_3000);
    exp_fetch(32'h0000_3000);
    step(1'b1, WA, 1'b0, 1'b0, 2'd0, '0);
    exp_issue(WA, 32'h0000_3000, 32'h0000_3004);
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, '0);

    @(negedge clk);
    #1;
    check("fetch_q_empty", 32'(addr_q.size()), 32'd0);
    check("issue_q_empty", 32'(issue_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
